// File: rtl/pipe_stage_latch.sv
`timescale 1ns/1ps
// Inter-stage pipeline register: NUM_CH packed channels, 1-cycle latency, valid/ready stall, flush bubble.
// Define PIPE_STAGE_SKID_EN for a registered in_ready backed by a 1-entry skid register.
module pipe_stage_latch #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_CH     = 4,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [NUM_CH*DATA_W-1:0] i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NUM_CH*DATA_W-1:0] o_out_data,
  output logic [1:0]               o_occupancy
);

  localparam int                W        = NUM_CH * DATA_W;
  localparam logic [W-1:0]      BUB_BUS  = {NUM_CH{BUBBLE_VAL}};

  logic         r_main_vld;
  logic [W-1:0] r_main_dat;
  logic         w_accept;
  logic         w_release;

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_release   = r_main_vld & i_out_ready;
  assign o_out_valid = r_main_vld;
  assign o_out_data  = r_main_dat;

`ifdef PIPE_STAGE_SKID_EN
  logic         r_skid_vld;
  logic [W-1:0] r_skid_dat;

  // Ready comes straight from a flop, so out_ready never reaches upstream combinationally.
  assign o_in_ready  = ~r_skid_vld;
  assign o_occupancy = {r_skid_vld, r_main_vld & ~r_skid_vld};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_main_vld <= 1'b0;
      r_main_dat <= BUB_BUS;
      r_skid_vld <= 1'b0;
      r_skid_dat <= BUB_BUS;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_main_dat <= BUB_BUS;
      r_skid_vld <= 1'b0;
    end else if (w_release) begin
      if (r_skid_vld) begin
        r_main_dat <= r_skid_dat;
        r_skid_vld <= 1'b0;
      end else if (w_accept) begin
        r_main_dat <= i_in_data;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_accept) begin
      // Main busy and stalled: park the word so upstream is not blocked this cycle.
      if (r_main_vld) begin
        r_skid_vld <= 1'b1;
        r_skid_dat <= i_in_data;
      end else begin
        r_main_vld <= 1'b1;
        r_main_dat <= i_in_data;
      end
    end
  end
`else
  assign o_in_ready  = i_out_ready | ~r_main_vld;
  assign o_occupancy = {1'b0, r_main_vld};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_main_vld <= 1'b0;
      r_main_dat <= BUB_BUS;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_main_dat <= BUB_BUS;
    end else if (w_accept) begin
      r_main_vld <= 1'b1;
      r_main_dat <= i_in_data;
    end else if (w_release) begin
      r_main_vld <= 1'b0;
    end
  end
`endif

endmodule
